led_change_uart: RTL and testbench
==================================

Name: led_change_uart

Overview:
- Downstream consumer of the Auto2 8-bit `leds` bus.
- Detects every change on the bus and queues the new value in a small FIFO.
- Streams each queued value over an 8N1 UART TX line as two uppercase ASCII hex characters followed by LF (0x0A).
- Gives debug/hardware visibility of the LED pattern sequence without a logic analyser.

Parameters:
- CLKS_PER_BIT, 4: clock cycles per UART bit; ≥2. Simulation uses 4; board uses 434.
- FIFO_AW, 2: FIFO address width. Depth = 2^FIFO_AW = 4 entries.

Ports:
- clock0  in  1  sole clock, rising-edge.
- reset  in  1  synchronous, active-low. reset==0 at a rising edge resets the block.
- leds  in  8  LED bus from Auto2; sampled every cycle.
- clear_overflow  in  1  single-cycle pulse; clears the overflow flag.
- tx  out  1  UART serial output, idle high.
- busy  out  1  high while a character frame is in progress (state != IDLE).
- overflow  out  1  sticky flag: a change was dropped because the FIFO was full.
- fifo_count  out  FIFO_AW+1  number of queued entries.

Behaviour:
- Reset values (reset==0 at edge):
  - tx=1, busy=0, overflow=0, fifo_count=0.
  - FIFO pointers cleared; last=8'h00.
  - FSM=IDLE; char index=0; bit/baud counters=0.
- Reset mid-frame aborts the frame immediately: tx=1 after that edge, with no partial stop bit.
- Change detect:
  - Register `last` loads `leds` every non-reset edge.
  - A push occurs at edge E when leds != last at E.
  - Consequence: after reset, any nonzero leds value is reported. A static value is never reported twice.
- FIFO push:
  - Not full: leds is written at E.
  - Full and no pop at E: value is dropped and overflow<=1.
  - Full with a pop at the same edge: push accepted, no overflow.
  - fifo_count updates at the same edge as the push/pop.
- Overflow flag:
  - Cleared by clear_overflow.
  - If a set and a clear occur at the same edge, set wins.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO non-empty at edge, pop head into hold register, char index=0, enter START. tx driven low from that edge.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits LSB first, each CLKS_PER_BIT cycles, then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
    - If char index<2: increment index, go directly to START (no idle gap).
    - Otherwise go to IDLE.
- Char select:
  - index 0 = hex(hold[7:4]).
  - index 1 = hex(hold[3:0]).
  - index 2 = 8'h0A.
  - hex(n) = 8'h30+n for n≤9; 8'h37+n for n≥10 (uppercase A-F).
- Timing:
  - Latency: leds change sampled at edge E (push), pop at E+1 if FSM idle, start bit visible from E+1.
  - One entry = 30*CLKS_PER_BIT cycles of frames, plus at least one IDLE cycle before the next pop.
- Hold register is stable for the whole 3-character entry. FIFO content changes never alter an in-flight entry.
- Pointer arithmetic wraps modulo 2^FIFO_AW. fifo_count saturates naturally at 2^FIFO_AW (full), never exceeds it.

Test Plan:
- Reset: hold reset=0 for 2 edges with leds=8'hFF → tx=1, busy=0, fifo_count=0, overflow=0. After release, first edge pushes 8'hFF (last was 0) and the transmission starts.
- Single change, CLKS_PER_BIT=4: leds 8'h00→8'hA5 → tx frames 8'h41, 8'h35, 8'h0A; each 40 cycles; start bit low the edge after the push; busy high for 120 cycles, then 1 IDLE cycle.
- Static bus: leds held 8'h3C for 500 cycles after its single report → exactly one entry sent ('3','C',LF); fifo_count returns to 0 and stays.
- Overflow: 6 distinct leds values on consecutive cycles → first popped, next 4 queued (fifo_count=4), 6th dropped, overflow=1. Five entries transmitted in order. clear_overflow pulse → overflow=0.
- Simultaneous events:
  - FIFO full and the pop edge coincides with a new change → push accepted, overflow stays 0.
  - clear_overflow on the same edge as a drop → overflow remains 1.
- Reset mid-operation: assert reset during DATA bit 3 of the second character, with 2 entries queued → next edge tx=1, fifo_count=0, busy=0. No further output until a new leds change.

Source files
------------

// File: rtl/led_change_uart_if.sv
// Bundle between the LED source and the change reporter: LED bus in, UART line and status out.
interface led_change_uart_if #(
  parameter int FIFO_AW = 2
);
  logic [7:0]       leds;
  logic             clear_overflow;
  logic             tx;
  logic             busy;
  logic             overflow;
  logic [FIFO_AW:0] fifo_count;

  modport master (
    output leds, clear_overflow,
    input  tx, busy, overflow, fifo_count
  );

  modport slave (
    input  leds, clear_overflow,
    output tx, busy, overflow, fifo_count
  );
endinterface

// File: rtl/led_change_uart.sv
// Queues every change of the LED bus and sends it as two hex chars + LF over 8N1 UART; start bit the edge after the push.
// No backpressure: a change arriving with the FIFO full and no pop is dropped and latches the sticky overflow flag.
module led_change_uart #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_AW      = 2
) (
  input  logic            clock0,
  input  logic            reset,
  led_change_uart_if.slave bus
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0]   COUNT_MAX = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   COUNT_ONE = (FIFO_AW + 1)'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic [7:0]         last;
  logic [7:0]         hold;
  logic [1:0]         char_idx;
  logic [2:0]         bit_idx;
  logic [CNT_W-1:0]   baud;
  logic               tx_q;
  logic               busy_q;
  logic               ovf_q;

  logic               change;
  logic               full;
  logic               pop;
  logic               push;
  logic               drop;
  logic [7:0]         ch;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // A full FIFO still accepts a change on the edge the transmitter pops.
  always_comb begin
    change = (bus.leds != last);
    full   = (count == COUNT_MAX);
    pop    = (state == IDLE) && (count != '0);
    push   = change && (!full || pop);
    drop   = change && full && !pop;
  end

  always_comb begin
    ch = 8'h0A;
    case (char_idx)
      2'd0:    ch = hex_char(hold[7:4]);
      2'd1:    ch = hex_char(hold[3:0]);
      default: ch = 8'h0A;
    endcase
  end

  always_ff @(posedge clock0) begin
    if (reset && push) begin
      mem[wr_ptr] <= bus.leds;
    end
  end

  always_ff @(posedge clock0) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last     <= 8'h00;
      ovf_q    <= 1'b0;
      state    <= IDLE;
      hold     <= 8'h00;
      char_idx <= 2'd0;
      bit_idx  <= 3'd0;
      baud     <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      last <= bus.leds;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase

      if (drop)                    ovf_q <= 1'b1;
      else if (bus.clear_overflow) ovf_q <= 1'b0;

      case (state)
        IDLE: begin
          if (pop) begin
            hold     <= mem[rd_ptr];
            char_idx <= 2'd0;
            baud     <= '0;
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          if (baud == CNT_LAST) begin
            baud    <= '0;
            bit_idx <= 3'd0;
            tx_q    <= ch[0];
            state   <= DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (baud == CNT_LAST) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              tx_q  <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_q    <= ch[bit_idx + 3'd1];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        STOP: begin
          if (baud == CNT_LAST) begin
            baud <= '0;
            if (char_idx < 2'd2) begin
              char_idx <= char_idx + 2'd1;
              tx_q     <= 1'b0;
              state    <= START;
            end else begin
              busy_q <= 1'b0;
              state  <= IDLE;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.overflow   = ovf_q;
  assign bus.fifo_count = count;
endmodule

// File: tb/tb_led_change_uart.sv
// Random and directed LED sequences against a queue/timing reference model; a UART receiver process scores the chars.
module tb_led_change_uart;
  localparam int CPB   = 4;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int ENTRY = 30 * CPB;

  logic clock0 = 1'b0;
  logic reset  = 1'b0;

  led_change_uart_if #(.FIFO_AW(AW)) bus ();

  led_change_uart #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .clock0 (clock0),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clock0 = ~clock0;

  int tests = 0;
  int fails = 0;

  byte unsigned mq[$];      // model FIFO contents
  byte unsigned exp_q[$];   // chars expected on the line, in order
  logic [7:0]   m_last = 8'h00;
  logic         m_ovf  = 1'b0;
  int           n        = 0;   // index of the next clock edge
  int           next_pop = 0;   // earliest edge the transmitter may take a new entry
  logic [7:0]   cur      = 8'h00;
  bit           rx_abort = 1'b0;
  bit           rx_on    = 1'b0;
  int           rx_cnt   = 0;
  logic [7:0]   rx_byte  = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, n, act, req);
    end
  endtask

  function automatic byte unsigned hexc(input int nib);
    return (nib < 10) ? byte'(48 + nib) : byte'(65 + nib - 10);
  endfunction

  // Apply inputs for one edge, advance the model, check status outputs just after the edge.
  task automatic step(input logic [7:0] l, input logic c, input logic r);
    bit do_pop, do_push, do_drop, popped, busy_exp;
    byte unsigned v;
    popped = 1'b0;
    cur = l;
    bus.leds = l;
    bus.clear_overflow = c;
    reset = r;
    @(posedge clock0);
    if (!r) begin
      mq.delete();
      exp_q.delete();
      m_last = 8'h00;
      m_ovf = 1'b0;
      next_pop = n + 1;
      rx_abort = 1'b1;
    end else begin
      do_pop  = (n >= next_pop) && (mq.size() != 0);
      do_push = (l != m_last);
      do_drop = do_push && (mq.size() == DEPTH) && !do_pop;
      if (do_pop) begin
        v = mq.pop_front();
        exp_q.push_back(hexc(int'(v) / 16));
        exp_q.push_back(hexc(int'(v) % 16));
        exp_q.push_back(8'h0A);
        next_pop = n + ENTRY + 1;
        popped = 1'b1;
      end
      if (do_push && !do_drop) mq.push_back(l);
      if (do_drop) m_ovf = 1'b1;
      else if (c) m_ovf = 1'b0;
      m_last = l;
    end
    busy_exp = (n < next_pop - 1);
    #1;
    chk("fifo_count", 32'(bus.fifo_count), 32'(mq.size()));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("busy", 32'(bus.busy), 32'(busy_exp));
    if (!busy_exp) chk("tx_idle_high", 32'(bus.tx), 32'd1);
    if (popped) chk("start_bit_latency", 32'(bus.tx), 32'd0);
    n++;
    @(negedge clock0);
  endtask

  task automatic drain(input int maxc);
    int k = 0;
    while ((mq.size() != 0 || n < next_pop) && k < maxc) begin
      step(cur, 1'b0, 1'b1);
      k++;
    end
    repeat (4) step(cur, 1'b0, 1'b1);
    if (k >= maxc) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d entries still queued after %0d cycles", mq.size(), maxc);
    end
  endtask

  // UART receiver: samples mid-bit on falling edges; reset aborts a frame in progress.
  initial begin
    forever begin
      @(negedge clock0);
      if (rx_abort) begin
        rx_abort = 1'b0;
        rx_on = 1'b0;
      end else if (!rx_on) begin
        if (bus.tx === 1'b0) begin
          rx_on = 1'b1;
          rx_cnt = 0;
        end
      end else begin
        rx_cnt++;
        if (rx_cnt % CPB == CPB / 2) begin
          if (rx_cnt / CPB == 0) begin
            chk("start_bit", 32'(bus.tx), 32'd0);
          end else if (rx_cnt / CPB <= 8) begin
            rx_byte[rx_cnt / CPB - 1] = bus.tx;
          end else begin
            chk("stop_bit", 32'(bus.tx), 32'd1);
            if (exp_q.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL unexpected_char: got %0h, expected none", rx_byte);
            end else begin
              chk("uart_char", 32'(rx_byte), 32'(exp_q.pop_front()));
            end
            rx_on = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] burst [6];
    int target;
    bus.leds = 8'h00;
    bus.clear_overflow = 1'b0;

    // Reset held two edges with the bus at FF
    step(8'hFF, 1'b0, 1'b0);
    step(8'hFF, 1'b0, 1'b0);
    chk("rst_tx", 32'(bus.tx), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_count", 32'(bus.fifo_count), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    step(8'hFF, 1'b0, 1'b1);
    chk("first_push_ff", 32'(bus.fifo_count), 32'd1);
    drain(400);

    // Single change to A5
    step(8'h00, 1'b0, 1'b1);
    drain(400);
    step(8'hA5, 1'b0, 1'b1);
    drain(400);

    // Static bus reported once
    step(8'h3C, 1'b0, 1'b1);
    repeat (500) step(8'h3C, 1'b0, 1'b1);
    chk("static_count", 32'(bus.fifo_count), 32'd0);

    // Overflow burst, clear coinciding with a drop, then clear
    burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    foreach (burst[i]) step(burst[i], 1'b0, 1'b1);
    chk("burst_count", 32'(bus.fifo_count), 32'd4);
    chk("burst_ovf", 32'(bus.overflow), 32'd1);
    step(8'h77, 1'b1, 1'b1);
    chk("clear_vs_drop", 32'(bus.overflow), 32'd1);
    step(8'h77, 1'b1, 1'b1);
    chk("clear_ovf", 32'(bus.overflow), 32'd0);
    while (n < next_pop) step(8'h77, 1'b0, 1'b1);
    step(8'h88, 1'b0, 1'b1);
    chk("full_pop_push_ovf", 32'(bus.overflow), 32'd0);
    chk("full_pop_push_count", 32'(bus.fifo_count), 32'd4);
    drain(1000);

    // Reset during DATA bit 3 of the second char with two entries queued
    step(8'h5A, 1'b0, 1'b1);
    step(8'h6B, 1'b0, 1'b1);
    step(8'h7C, 1'b0, 1'b1);
    chk("mid_count", 32'(bus.fifo_count), 32'd2);
    target = (next_pop - ENTRY - 1) + 14 * CPB + 1;
    while (n < target) step(8'h7C, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b0);
    chk("mid_rst_tx", 32'(bus.tx), 32'd1);
    chk("mid_rst_count", 32'(bus.fifo_count), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    repeat (150) step(8'h00, 1'b0, 1'b1);
    step(8'hC3, 1'b0, 1'b1);
    drain(400);

    // Random traffic with occasional bursts, clears and resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        repeat (6) step(8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
      end else begin
        if ($urandom_range(0, 29) == 0) cur = 8'($urandom);
        step(cur, ($urandom_range(0, 39) == 0), ($urandom_range(0, 999) != 0));
      end
    end
    drain(1500);

    chk("all_chars_received", 32'(exp_q.size()), 32'd0);
    chk("receiver_idle", 32'(rx_on), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
